// File: rtl/egress_tx.sv
// Egress transmitter: parses header/length frames from a FIFO and
// streams them out through a 2-entry skid buffer with sop/eop tags.
module egress_tx #(
  parameter int LEN_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_dout,
  output logic        fifo_rd_en,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  output logic        tx_sop,
  output logic        tx_eop,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  typedef enum logic {
    IDLE,
    PAYLOAD
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [LEN_BITS-1:0] rem;
  logic [LEN_BITS-1:0] rem_nxt;
  logic [LEN_BITS-1:0] hdr_len;
  logic [1:0]          occ;
  logic                pend;
  // entries are {sop, eop, data}; buf0 is the oldest
  logic [33:0]         buf0;
  logic [33:0]         buf1;
  logic [33:0]         wr_entry;
  logic                tag_sop;
  logic                tag_eop;
  logic                pop;
  logic [2:0]          level;

  assign hdr_len  = fifo_dout[LEN_BITS-1:0];
  assign pop      = tx_valid && tx_ready;
  assign wr_entry = {tag_sop, tag_eop, fifo_dout};

  // Occupancy after this cycle's pop, counting the word in flight.
  assign level = {1'b0, occ} + {2'b0, pend} - {2'b0, pop};

  assign fifo_rd_en = !fifo_empty && !reset && (level < 3'd2);

  assign tx_valid = !reset && (occ != 2'd0);
  assign tx_data  = tx_valid ? buf0[31:0] : 32'd0;
  assign tx_sop   = tx_valid && buf0[33];
  assign tx_eop   = tx_valid && buf0[32];

  assign busy = !reset &&
                ((state != IDLE) || (occ != 2'd0) || pend);

  // Parser state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  // Parser next state and sop/eop tagging of the arriving word.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    tag_sop   = 1'b0;
    tag_eop   = 1'b0;
    if (pend) begin
      unique case (state)
        IDLE: begin
          tag_sop = 1'b1;
          if (hdr_len == '0) begin
            tag_eop = 1'b1;
          end else begin
            rem_nxt   = hdr_len;
            state_nxt = PAYLOAD;
          end
        end
        PAYLOAD: begin
          rem_nxt = rem - LEN_BITS'(1);
          if (rem == LEN_BITS'(1)) begin
            tag_eop   = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Two-entry output buffer; pend marks read data arriving this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ  <= 2'd0;
      pend <= 1'b0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      pend <= fifo_rd_en;
      case ({pend, pop})
        2'b10: begin
          if (occ == 2'd0) buf0 <= wr_entry;
          else             buf1 <= wr_entry;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            buf0 <= buf1;
            buf1 <= wr_entry;
          end else begin
            buf0 <= wr_entry;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Count frames whose last word has been accepted downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= 16'd0;
    end else if (pop && buf0[32]) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_egress_tx.sv
// Directed bench for egress_tx: FIFO model plus scoreboard of
// expected {sop, eop, data} beats checked as they leave the DUT.
module tb_egress_tx;

  logic        clk;
  logic        reset;
  logic        fifo_empty;
  logic [31:0] fifo_dout;
  logic        fifo_rd_en;
  logic        tx_ready;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_sop;
  logic        tx_eop;
  logic        busy;
  logic [15:0] frame_cnt;

  int          n_checks;
  int          n_errs;
  logic [31:0] fifo_q[$];
  logic [33:0] exp_q[$];
  logic [15:0] mdl_cnt;

  egress_tx #(.LEN_BITS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .tx_ready   (tx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_sop     (tx_sop),
    .tx_eop     (tx_eop),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [33:0] got,
                     input logic [33:0] want);
    n_checks++;
    assert (got === want) else begin
      n_errs++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Upstream FIFO: data appears the cycle after a pop.
  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() > 0) begin
      fifo_dout  <= fifo_q.pop_front();
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Scoreboard and per-cycle output rules.
  always @(negedge clk) begin
    if (reset) begin
      mdl_cnt = 16'd0;
    end else begin
      chk("frame_cnt", {18'd0, frame_cnt}, {18'd0, mdl_cnt});
      chk("rd_when_empty", {33'd0, fifo_rd_en && fifo_empty}, 34'd0);
      if (!tx_valid)
        chk("idle_outputs", {tx_sop, tx_eop, tx_data}, 34'd0);
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {tx_sop, tx_eop, tx_data}, 34'h3_dead_beef);
        end else begin
          logic [33:0] e;
          e = exp_q.pop_front();
          chk("beat", {tx_sop, tx_eop, tx_data}, e);
          if (e[32]) mdl_cnt = mdl_cnt + 16'd1;
        end
      end
    end
  end

  task automatic push_word(input logic [31:0] d, input logic s,
                           input logic e, input bit track);
    fifo_q.push_back(d);
    fifo_empty = 1'b0;
    if (track) exp_q.push_back({s, e, d});
  endtask

  task automatic push_frame(input logic [31:0] hdr, input logic [31:0] base);
    int n;
    n = int'(hdr[7:0]);
    push_word(hdr, 1'b1, n == 0, 1'b1);
    for (int i = 0; i < n; i++)
      push_word(base + 32'(i), 1'b0, i == n - 1, 1'b1);
  endtask

  task automatic drain(input int budget, input string tag,
                       input bit check_idle);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_timeout"}, {33'd0, k >= budget}, 34'd0);
    @(negedge clk);
    chk({tag, "_valid_low"}, {33'd0, tx_valid}, 34'd0);
    if (check_idle) chk({tag, "_busy_low"}, {33'd0, busy}, 34'd0);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] held;
    int          k;
    n_checks   = 0;
    n_errs     = 0;
    mdl_cnt    = 16'd0;
    reset      = 1'b1;
    tx_ready   = 1'b1;
    fifo_empty = 1'b1;
    fifo_dout  = 32'd0;

    // Reset held 2 cycles with a non-empty FIFO.
    push_word(32'h0000_0007, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_rd_en", {33'd0, fifo_rd_en}, 34'd0);
      chk("rst_valid", {33'd0, tx_valid}, 34'd0);
      chk("rst_busy", {33'd0, busy}, 34'd0);
      chk("rst_cnt", {18'd0, frame_cnt}, 34'd0);
    end
    step();
    fifo_q.delete();
    fifo_empty = 1'b1;
    reset = 1'b0;

    // Basic frame, checked for back-to-back beats.
    push_frame(32'h0000_0003, 32'hA0A0_0000);
    k = 0;
    @(negedge clk);
    while (!tx_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("basic_start", {33'd0, k >= 10}, 34'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("basic_stream", {33'd0, tx_valid}, 34'd1);
    end
    drain(50, "basic", 1'b1);
    chk("basic_cnt", {18'd0, frame_cnt}, 34'd1);

    // Header-only frame, then a frame that must start with sop.
    push_frame(32'h0000_0100, 32'h0);
    push_frame(32'h0000_0002, 32'hB0B0_0000);
    drain(50, "hdr_only", 1'b1);
    chk("hdr_only_cnt", {18'd0, frame_cnt}, 34'd3);

    // Backpressure: stall 5 cycles after 2 beats of a 7-word frame.
    push_frame(32'h0000_0006, 32'hC0C0_0000);
    k = 0;
    while (exp_q.size() > 5 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("bp_start", {33'd0, k >= 20}, 34'd0);
    step();
    tx_ready = 1'b0;
    @(negedge clk);
    held = tx_data;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_valid", {33'd0, tx_valid}, 34'd1);
      chk("bp_rd_en", {33'd0, fifo_rd_en}, 34'd0);
      chk("bp_hold", {2'b00, tx_data}, {2'b00, held});
    end
    step();
    tx_ready = 1'b1;
    drain(50, "bp", 1'b1);

    // Reset mid-frame after 2 of 5 payload words.
    push_word(32'h0000_0005, 1'b1, 1'b0, 1'b1);
    push_word(32'hD0D0_0001, 1'b0, 1'b0, 1'b1);
    push_word(32'hD0D0_0002, 1'b0, 1'b0, 1'b1);
    drain(50, "mid", 1'b0);
    step();
    tx_ready = 1'b0;
    for (int i = 3; i <= 5; i++)
      push_word(32'hD0D0_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("mid_busy", {33'd0, busy}, 34'd1);
    chk("mid_full", {33'd0, tx_valid}, 34'd1);
    step();
    reset = 1'b1;
    fifo_q.delete();
    fifo_empty = 1'b1;
    @(negedge clk);
    chk("mid_rst_out", {tx_sop, tx_eop, tx_data}, 34'd0);
    chk("mid_rst_valid", {33'd0, tx_valid}, 34'd0);
    chk("mid_rst_busy", {33'd0, busy}, 34'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_post_valid", {33'd0, tx_valid}, 34'd0);
    chk("mid_post_busy", {33'd0, busy}, 34'd0);
    step();
    tx_ready = 1'b1;
    push_frame(32'h0000_0001, 32'h0000_000D);
    drain(50, "mid_after", 1'b1);
    chk("mid_after_cnt", {18'd0, frame_cnt}, 34'd1);

    // Counter wrap with 65537 header-only frames.
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 65537; i++)
      push_frame(32'(i) << 8, 32'h0);
    drain(70000, "wrap", 1'b1);
    chk("wrap_cnt", {18'd0, frame_cnt}, 34'h0001);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errs);
    $finish;
  end

endmodule
